// File: rtl/seg_scan_drv.sv
// Time-multiplexed common-anode seven-segment driver with double-buffered display data.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_drv #(
   parameter int unsigned DIGITS    = 8,
   parameter int unsigned SCAN_DIV  = 1000,
   parameter int unsigned BLANK_CYC = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_mask,
   output logic [7:0]            seg_out,
   output logic [DIGITS-1:0]     an_out,
   output logic                  frame_done
);

   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned CW = $clog2(SCAN_DIV);

   logic [CW-1:0]         div_cnt;
   logic [IW-1:0]         idx;
   logic [4*DIGITS-1:0]   hold_val, shadow_val;
   logic [DIGITS-1:0]     hold_dp, shadow_dp;
   logic                  pending;

   logic                  slot_end, wrap, show, lit, cur_dp;
   logic [3:0]            cur_nib;
   logic [7:0]            glyph;

   function automatic logic [7:0] hex_glyph(input logic [3:0] n);
      logic [7:0] g;
      case (n)
         4'h0: g = 8'hFC;
         4'h1: g = 8'h60;
         4'h2: g = 8'hDA;
         4'h3: g = 8'hF2;
         4'h4: g = 8'h66;
         4'h5: g = 8'hB6;
         4'h6: g = 8'hBE;
         4'h7: g = 8'hE0;
         4'h8: g = 8'hFE;
         4'h9: g = 8'hF6;
         4'hA: g = 8'hEE;
         4'hB: g = 8'h3E;
         4'hC: g = 8'h9C;
         4'hD: g = 8'h7A;
         4'hE: g = 8'h9E;
         default: g = 8'h8E;
      endcase
      return g;
   endfunction

   assign slot_end = en && (div_cnt == CW'(SCAN_DIV - 1));
   assign wrap     = slot_end && (idx == IW'(DIGITS - 1));

   always_comb begin
      cur_nib = 4'h0;
      cur_dp  = 1'b0;
      for (int k = 0; k < int'(DIGITS); k++) begin
         if (idx == IW'(k)) begin
            cur_nib = shadow_val[4*k +: 4];
            cur_dp  = shadow_dp[k];
         end
      end
   end

`ifdef SEG_SCAN_LZB_EN
   logic [IW-1:0] hi_idx;

   // Highest non-zero nibble; digit 0 stays visible because hi_idx never drops below 0.
   always_comb begin
      hi_idx = '0;
      for (int k = 0; k < int'(DIGITS); k++) begin
         if (shadow_val[4*k +: 4] != 4'h0) hi_idx = IW'(k);
      end
   end

   assign show = (idx <= hi_idx) || cur_dp;
`else
   assign show = 1'b1;
`endif

   assign glyph = hex_glyph(cur_nib) | {7'b0, cur_dp};
   assign lit   = en && (div_cnt >= CW'(BLANK_CYC)) && show;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_out    <= 8'hFF;
         an_out     <= '1;
         frame_done <= 1'b0;
         div_cnt    <= '0;
         idx        <= '0;
         hold_val   <= '0;
         hold_dp    <= '0;
         shadow_val <= '0;
         shadow_dp  <= '0;
         pending    <= 1'b0;
      end else begin
         frame_done <= wrap;
         if (lit) begin
            an_out  <= ~(DIGITS'(1) << idx);
            seg_out <= ~glyph;
         end else begin
            an_out  <= '1;
            seg_out <= 8'hFF;
         end

         if (en) begin
            if (slot_end) begin
               div_cnt <= '0;
               idx     <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
               div_cnt <= div_cnt + CW'(1);
            end
         end

         // A load landing on the wrap edge bypasses the hold stage entirely.
         if (load && wrap) begin
            hold_val   <= value;
            hold_dp    <= dp_mask;
            shadow_val <= value;
            shadow_dp  <= dp_mask;
            pending    <= 1'b0;
         end else if (load) begin
            hold_val <= value;
            hold_dp  <= dp_mask;
            pending  <= 1'b1;
         end else if (wrap && pending) begin
            shadow_val <= hold_val;
            shadow_dp  <= hold_dp;
            pending    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_drv.sv
// Self-checking bench for seg_scan_drv: frame-position reference model plus directed literals.
module tb_seg_scan_drv;
   localparam int D  = 4;
   localparam int SD = 4;
   localparam int BC = 1;
   localparam int FR = D * SD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_mask = '0;
   logic [7:0]  seg_out;
   logic [3:0]  an_out;
   logic        frame_done;

   int total = 0;
   int bad = 0;
   bit chk_on = 1'b0;

   seg_scan_drv #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
      .clk(clk), .rst(rst), .en(en), .load(load), .value(value), .dp_mask(dp_mask),
      .seg_out(seg_out), .an_out(an_out), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a single position counter over the whole frame plus shown/held buffers.
   logic [7:0] gtab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                             8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
   int          pos;
   logic [15:0] shown, held;
   logic [3:0]  shown_dp, held_dp;
   bit          pend;
   logic [7:0]  exp_seg;
   logic [3:0]  exp_an;
   logic        exp_fd;

   always @(posedge clk or posedge rst) begin : model
      int dig, sub;
      bit wrap, vis;
      logic [3:0] nib;
      if (rst) begin
         pos = 0; shown = '0; held = '0; shown_dp = '0; held_dp = '0; pend = 0;
         exp_seg = 8'hFF; exp_an = 4'hF; exp_fd = 1'b0;
      end else begin
         exp_seg = 8'hFF; exp_an = 4'hF; exp_fd = 1'b0; wrap = 0;
         if (en) begin
            dig = pos / SD;
            sub = pos % SD;
            nib = shown[4*dig +: 4];
            vis = 1;
`ifdef SEG_SCAN_LZB_EN
            vis = (dig == 0) || shown_dp[dig] || ((shown >> (4*dig)) != 16'h0);
`endif
            if (sub >= BC && vis) begin
               exp_an  = 4'hF ^ (4'd1 << dig);
               exp_seg = ~(gtab[nib] | {7'd0, shown_dp[dig]});
            end
            wrap   = (pos == FR - 1);
            exp_fd = wrap;
            pos    = (pos + 1) % FR;
         end
         if (load && wrap) begin
            shown = value; shown_dp = dp_mask; held = value; held_dp = dp_mask; pend = 0;
         end else if (load) begin
            held = value; held_dp = dp_mask; pend = 1;
         end else if (wrap && pend) begin
            shown = held; shown_dp = held_dp; pend = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && chk_on) begin
         chk("model_seg", seg_out, exp_seg);
         chk("model_an", an_out, exp_an);
         chk("model_fd", frame_done, exp_fd);
      end
   end

   task automatic load_val(input logic [15:0] v, input logic [3:0] m);
      value = v; dp_mask = m; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_fd(input string name);
      int n = 0;
      @(negedge clk);
      while (frame_done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk(name, frame_done, 1);
   endtask

   task automatic wait_lit(input logic [3:0] an, input logic [7:0] seg, input string name);
      int n = 0;
      while (an_out !== an && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_an"}, an_out, an);
      chk({name, "_seg"}, seg_out, seg);
   endtask

   logic [3:0] lit_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [7:0] lit_seg [4] = '{8'h71, 8'h0D, 8'h11, 8'h9F};

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_seg", seg_out, 8'hFF);
      chk("reset_an", an_out, 4'hF);
      rst = 1'b0; en = 1'b1; chk_on = 1'b1;
      wait_lit(4'hE, 8'h03, "first_digit0");

      load_val(16'h1A3F, 4'h0);
      wait_fd("fd_after_load");
      for (int d = 0; d < D; d++) begin
         @(negedge clk);
         chk("slot_blank_an", an_out, 4'hF);
         repeat (3) begin
            @(negedge clk);
            chk("slot_an", an_out, lit_an[d]);
            chk("slot_seg", seg_out, lit_seg[d]);
         end
      end
      chk("fd_period16", frame_done, 1);

      load_val(16'h1A3F, 4'b0001);
      wait_fd("fd_after_dp");
      repeat (2) @(negedge clk);
      chk("dp_digit0_an", an_out, 4'hE);
      chk("dp_digit0_seg", seg_out, 8'h70);

      wait_lit(4'hB, 8'h11, "digit2_before_pause");
      en = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("pause_an", an_out, 4'hF);
         chk("pause_fd", frame_done, 0);
      end
      en = 1'b1;

      repeat (3000) begin
         @(negedge clk);
         en      = ($urandom % 10) != 0;
         load    = ($urandom % 6) == 0;
         value   = 16'($urandom);
         dp_mask = 4'($urandom);
      end
      @(negedge clk);
      load = 1'b0; en = 1'b1;
      repeat (7) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midreset_seg", seg_out, 8'hFF);
      chk("midreset_an", an_out, 4'hF);
      chk("midreset_fd", frame_done, 0);
      @(negedge clk);
      rst = 1'b0;
      wait_lit(4'hE, 8'h03, "post_reset_digit0");

`ifdef SEG_SCAN_LZB_EN
      load_val(16'h0005, 4'h0);
      wait_fd("lzb_fd1");
      repeat (FR) begin
         @(negedge clk);
         chk("lzb_only_d0", (an_out == 4'hF) || (an_out == 4'hE && seg_out == 8'h49), 1);
      end
      load_val(16'h0000, 4'b0100);
      wait_fd("lzb_fd2");
      wait_lit(4'hB, 8'h02, "lzb_dp_digit2");
`endif

      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg_scan_drv.md
Name: seg_scan_drv

Overview:
- Time-multiplexed driver for a bank of common-anode seven-segment digits.
- Takes a packed hex value plus per-digit decimal points and scans one digit at a time at a programmable rate.
- Drives the shared segment bus and a one-hot, active-low digit-select bus.
- Sits between register/counter logic and board pins; generalises the single-digit hex decoder to N digits, with frame-synchronous update, inter-digit blanking and a frame strobe.

Parameters:
- DIGITS, 8: number of digits scanned (1..16).
- SCAN_DIV, 1000: clock cycles each digit stays selected (>=2).
- BLANK_CYC, 1: cycles at the start of each digit slot with all anodes off (anti-ghosting); must be < SCAN_DIV.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  scan enable; 0 = display dark, counters frozen.
- load  input  1  one-cycle strobe; captures value/dp_mask.
- value  input  4*DIGITS  hex nibbles; nibble k = digit k, digit 0 rightmost.
- dp_mask  input  DIGITS  decimal-point enable per digit.
- seg_out  output  8  segments {a,b,c,d,e,f,g,dp}, bit7=a, bit0=dp, active-low.
- an_out  output  DIGITS  digit select, one-hot, active-low.
- frame_done  output  1  one-cycle pulse when the last digit slot ends.

Behaviour:
- Reset (async, immediate) values:
  - seg_out=8'hFF, an_out=all 1, frame_done=0.
  - div_cnt=0, idx=0.
  - Hold and shadow registers = 0; pending=0.
- Glyph encoding (active-high before inversion), 0..F: FC,60,DA,F2,66,B6,BE,E0,FE,F6,EE,3E,9C,7A,9E,8E.
  - dp_mask[idx] ORs in bit0.
  - Result is inverted onto seg_out.
- div_cnt counts 0..SCAN_DIV-1 while en=1.
  - At SCAN_DIV-1: div_cnt->0, idx->idx+1.
  - idx wraps DIGITS-1->0; on that wrap cycle frame_done=1.
- Outputs are registered and reflect the div_cnt/idx of the previous cycle (latency 1).
- While div_cnt<BLANK_CYC: an_out=all 1, seg_out=8'hFF.
- Otherwise: an_out bit idx=0, others 1, and seg_out = glyph(shadow nibble idx).
- Double buffering:
  - load copies value/dp_mask into hold and sets pending.
  - On the frame wrap cycle, if pending: shadow<=hold, pending<=0.
  - The display never changes mid-frame.
- Boundary cases:
  - load coincident with the wrap cycle: the new value goes directly into both hold and shadow, and pending stays 0.
  - Repeated loads within a frame: last one wins.
- en=0:
  - div_cnt/idx hold their value; outputs are all-off on the next cycle; frame_done=0.
  - load is still accepted.
  - Resuming continues from the frozen position.
- DIGITS=1: idx is constant 0 and frame_done pulses every SCAN_DIV cycles.
- Reset mid-frame: everything returns to reset values; any pending load is discarded.

Optional Feature:
- Macro: SEG_SCAN_LZB_EN.
- Defined: leading-zero blanking. Digits above the highest non-zero shadow nibble keep their anode off for their whole slot; timing is unchanged. Digit 0 is always shown, so value 0 displays "0". A digit whose dp_mask bit is set is never blanked.
- Undefined: all DIGITS are always shown.

Test Plan (DIGITS=4, SCAN_DIV=4, BLANK_CYC=1 unless noted):
- Reset asserted mid-scan -> same cycle seg_out=8'hFF, an_out=4'hF, frame_done=0; after release with en=1, first lit slot is digit 0 showing seg_out=8'h03 ("0").
- load value=16'h1A3F, dp_mask=0 -> after the next frame_done:
  - digit 0: an_out=4'b1110, seg_out=8'h71.
  - digit 1: 4'b1101, 8'h0D.
  - digit 2: 4'b1011, 8'h11.
  - digit 3: 4'b0111, 8'h9F.
  - Each digit lit for 3 cycles after 1 blank cycle.
- dp_mask=4'b0001 with digit 0='F' -> seg_out=8'h70 during digit 0 only; frame_done pulses exactly every 16 cycles.
- load 16'h2222 at mid-frame (idx=1) -> digits 1..3 keep old glyphs to frame end; new glyphs from the next frame; load on the wrap cycle -> new glyphs from the very next slot.
- en dropped at idx=2, div_cnt=2 for 10 cycles -> outputs all-off, no frame_done; on re-enable, digit 2 resumes and finishes remaining slot cycles before digit 3.
- With SEG_SCAN_LZB_EN, value=16'h0005 -> only digit 0 anode ever asserts (8'h49); value=16'h0000 -> digit 0 shows "0"; dp_mask=4'b0100 -> digit 2 shows "0." (8'h02).
